axi4_s_bus_wr_ctrl: RTL and testbench
=====================================

// Module: axi4_s_bus_wr_ctrl
// PURPOSE
//  Write-side sequencer behind the AXI4-Lite slave write FIFOs (AW/W/B). Pops one AW + one W entry,
//  decodes the address, drives a single-beat register-bus write, waits for ack or timeout, then
//  pushes one B response. One outstanding write; strict AW/W pairing, in-order responses.
// PARAMETERS
//  A_W      32           address width (matches AW FIFO address field)
//  D_W      32           data width; strobe width is D_W/8
//  BASE     'h0000_0000  first decoded byte address
//  SIZE     'h0001_0000  decoded window size in bytes; addr outside [BASE, BASE+SIZE) -> DECERR
//  TIMEOUT  256          max cycles in REQ without ack; 0 = no timeout
//  CNT_W    16           width of error counter
// PORTS
//  aclk          in   1        clock
//  aresetn       in   1        asynchronous active-low reset
//  aw_rd_empty   in   1        AW FIFO empty (first-word-fall-through head)
//  aw_rd_en      out  1        AW FIFO pop
//  aw_addr       in   A_W      AW FIFO head address
//  w_rd_empty    in   1        W FIFO empty
//  w_rd_en       out  1        W FIFO pop
//  w_data        in   D_W      W FIFO head data
//  w_strb        in   D_W/8    W FIFO head strobes
//  b_wr_full     in   1        B FIFO full
//  b_wr_en       out  1        B FIFO push
//  b_resp        out  2        B FIFO write data (bresp)
//  reg_wr_req    out  1        register-bus write request, held until ack or timeout
//  reg_addr      out  A_W      write address (aw_addr - BASE)
//  reg_wdata     out  D_W      write data
//  reg_wstrb     out  D_W/8    write strobes
//  reg_ack       in   1        target ack; sampled only while reg_wr_req=1
//  reg_err       in   1        qualifies reg_ack: 1 -> SLVERR
//  busy          out  1        1 whenever state != IDLE
//  err_cnt       out  CNT_W    saturating count of non-OKAY responses pushed
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; reg_wr_req=0, b_resp=2'b00, captured
//    addr/data/strb=0, timer=0, err_cnt=0. Reset mid-transaction abandons it; no B is pushed.
//  - FSM IDLE -> REQ | RESP, REQ -> RESP, RESP -> IDLE.
//  - IDLE: aw_rd_en = w_rd_en = ~aw_rd_empty & ~w_rd_empty (combinational, same cycle).
//    - On pop, register addr/data/strb.
//    - In window -> REQ. Out of window -> b_resp=DECERR (2'b11), RESP; no bus access.
//    - Neither FIFO is popped alone; a lone AW or lone W waits.
//  - REQ: reg_wr_req=1, outputs stable.
//    - reg_ack=1: b_resp = reg_err ? SLVERR (2'b10) : OKAY (2'b00); reg_wr_req drops next cycle -> RESP.
//    - Else, if TIMEOUT!=0 and timer==TIMEOUT-1: b_resp=SLVERR, drop req -> RESP.
//    - Ack in the same cycle as expiry wins.
//    - Timer clears on REQ entry and increments each REQ cycle.
//  - RESP: b_wr_en = ~b_wr_full; on push -> IDLE. Full B FIFO stalls in RESP indefinitely.
//  - Zero strobes still issue a bus write; the target decides.
//  - Window check uses A_W+1-bit arithmetic; BASE+SIZE overflow must not alias. reg_addr wraps mod 2^A_W.
//  - err_cnt increments on b_wr_en with b_resp!=OKAY and saturates at all-ones.
//  - Best case: heads valid at cycle 0, pop at 0, req at 1, ack at 1, push at 2, IDLE at 3.
//    Throughput is 1 write per 3 cycles.
// STRUCTURE
//  - Package axi4_bus_pkg:
//    - typedef enum logic [1:0] axi4_resp_t {OKAY, EXOKAY, SLVERR, DECERR}
//    - typedef enum wr_ctrl_state_t {IDLE, REQ, RESP}
//  - No sub-module. Decode, timer and counter are inline; this block is instanced beside
//    axi4_s_bus_wr_fifos.
// TESTING
//  1. AW(0x10) + W(0xA5A5_A5A5, strb 0xF), ack at first REQ cycle
//     -> reg_addr=0x10, one req cycle, b_resp=OKAY pushed at cycle 2, err_cnt=0.
//  2. AW only, W arrives 5 cycles later
//     -> no pops until both present; a single pop pair, then a normal write.
//  3. aw_addr=BASE+SIZE (0x1_0000)
//     -> no reg_wr_req, b_resp=DECERR, err_cnt=1.
//  4. TIMEOUT=8, reg_ack never
//     -> req held exactly 8 cycles, SLVERR pushed. Ack at cycle 8 (the expiry cycle) -> OKAY instead.
//  5. b_wr_full=1 for 10 cycles in RESP
//     -> b_wr_en=0 and no pops meanwhile; push on the first non-full cycle.
//     Then aresetn pulsed during REQ -> all outputs at reset values, next pair processed cleanly.

Source files
------------

// File: rtl/axi4_bus_pkg.sv
// rtl/axi4_bus_pkg.sv - AXI4 response codes and write-sequencer states
package axi4_bus_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi4_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } wr_ctrl_state_t;

endpackage

// File: rtl/axi4_s_bus_wr_ctrl.sv
// rtl/axi4_s_bus_wr_ctrl.sv - pops AW/W pairs, issues one register-bus write, pushes one B response
module axi4_s_bus_wr_ctrl
    import axi4_bus_pkg::*;
#(
    parameter int unsigned    A_W     = 32,
    parameter int unsigned    D_W     = 32,
    parameter logic [A_W-1:0] BASE    = 'h0000_0000,
    parameter logic [A_W:0]   SIZE    = 'h0001_0000,
    parameter int unsigned    TIMEOUT = 256,
    parameter int unsigned    CNT_W   = 16
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               aw_rd_empty,
    output logic               aw_rd_en,
    input  logic [A_W-1:0]     aw_addr,
    input  logic               w_rd_empty,
    output logic               w_rd_en,
    input  logic [D_W-1:0]     w_data,
    input  logic [D_W/8-1:0]   w_strb,
    input  logic               b_wr_full,
    output logic               b_wr_en,
    output logic [1:0]         b_resp,
    output logic               reg_wr_req,
    output logic [A_W-1:0]     reg_addr,
    output logic [D_W-1:0]     reg_wdata,
    output logic [D_W/8-1:0]   reg_wstrb,
    input  logic               reg_ack,
    input  logic               reg_err,
    output logic               busy,
    output logic [CNT_W-1:0]   err_cnt
);

    wr_ctrl_state_t state;
    logic [31:0]    timer;
    logic           pop;
    logic           in_window;
    logic [A_W:0]   addr_ext;
    logic [A_W:0]   win_lo;
    logic [A_W:0]   win_hi;

    // One extra bit keeps BASE+SIZE from wrapping back into low addresses.
    assign addr_ext  = {1'b0, aw_addr};
    assign win_lo    = {1'b0, BASE};
    assign win_hi    = win_lo + SIZE;
    assign in_window = (addr_ext >= win_lo) && (addr_ext < win_hi);

    assign pop      = (state == IDLE) && !aw_rd_empty && !w_rd_empty;
    assign aw_rd_en = pop;
    assign w_rd_en  = pop;
    assign b_wr_en  = (state == RESP) && !b_wr_full;
    assign busy     = (state != IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            timer      <= '0;
            reg_wr_req <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_wstrb  <= '0;
            b_resp     <= OKAY;
            err_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        reg_addr  <= aw_addr - BASE;
                        reg_wdata <= w_data;
                        reg_wstrb <= w_strb;
                        if (in_window) begin
                            timer      <= '0;
                            reg_wr_req <= 1'b1;
                            state      <= REQ;
                        end else begin
                            b_resp <= DECERR;
                            state  <= RESP;
                        end
                    end
                end
                REQ: begin
                    // An ack arriving in the expiry cycle still completes normally.
                    if (reg_ack) begin
                        b_resp     <= reg_err ? SLVERR : OKAY;
                        reg_wr_req <= 1'b0;
                        state      <= RESP;
                    end else if ((TIMEOUT != 0) && (timer == TIMEOUT - 32'd1)) begin
                        b_resp     <= SLVERR;
                        reg_wr_req <= 1'b0;
                        state      <= RESP;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                RESP: begin
                    if (!b_wr_full) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    reg_wr_req <= 1'b0;
                end
            endcase

            if (b_wr_en && (b_resp != OKAY) && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi4_s_bus_wr_ctrl.sv
// tb/tb_axi4_s_bus_wr_ctrl.sv - randomized bench with FIFO/target stubs and a transaction-level model
module tb_axi4_s_bus_wr_ctrl;
    import axi4_bus_pkg::*;

    localparam int          TMO    = 8;
    localparam logic [31:0] BASE_P = 32'h0000_0000;
    localparam logic [32:0] SIZE_P = 33'h0_0001_0000;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        aw_rd_empty = 1'b1;
    logic        aw_rd_en;
    logic [31:0] aw_addr = '0;
    logic        w_rd_empty = 1'b1;
    logic        w_rd_en;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        b_wr_full = 1'b0;
    logic        b_wr_en;
    logic [1:0]  b_resp;
    logic        reg_wr_req;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_ack = 1'b0;
    logic        reg_err = 1'b0;
    logic        busy;
    logic [15:0] err_cnt;

    axi4_s_bus_wr_ctrl #(
        .A_W(32), .D_W(32), .BASE(BASE_P), .SIZE(SIZE_P), .TIMEOUT(TMO), .CNT_W(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .aw_rd_empty(aw_rd_empty), .aw_rd_en(aw_rd_en), .aw_addr(aw_addr),
        .w_rd_empty(w_rd_empty), .w_rd_en(w_rd_en), .w_data(w_data), .w_strb(w_strb),
        .b_wr_full(b_wr_full), .b_wr_en(b_wr_en), .b_resp(b_resp),
        .reg_wr_req(reg_wr_req), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
        .reg_ack(reg_ack), .reg_err(reg_err), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 aclk = ~aclk;

    int n_pass = 0;
    int n_total = 0;

    // FIFO contents, target behaviour per bus write, and observed event logs
    logic [31:0] aw_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];
    int          ack_q[$];
    logic        err_q[$];
    int          cur_ack = 1;
    logic        cur_err = 1'b0;
    int          full_left = 0;
    bit          rand_full = 0;

    int          cyc = 0;
    int          req_len = 0;
    int          pops = 0;
    int          stall = 0;
    int          inv_bad = 0;
    int          exp_err = 0;
    int          pop_cyc_q[$];
    int          req_cyc_q[$];
    int          req_len_q[$];
    int          push_cyc_q[$];
    logic [31:0] req_addr_q[$];
    logic [31:0] req_data_q[$];
    logic [3:0]  req_strb_q[$];
    logic [1:0]  resp_q[$];

    task automatic drive_heads();
        aw_rd_empty = (aw_q.size() == 0);
        if (aw_q.size() > 0) aw_addr = aw_q[0];
        else aw_addr = $urandom;
        w_rd_empty = (wd_q.size() == 0);
        if (wd_q.size() > 0) begin
            w_data = wd_q[0];
            w_strb = ws_q[0];
        end else begin
            w_data = $urandom;
            w_strb = 4'($urandom_range(15));
        end
    endtask

    task automatic clear_logs();
        pop_cyc_q.delete(); req_cyc_q.delete(); req_len_q.delete(); push_cyc_q.delete();
        req_addr_q.delete(); req_data_q.delete(); req_strb_q.delete(); resp_q.delete();
        pops = 0; stall = 0; inv_bad = 0;
    endtask

    task automatic tick();
        bit popped;
        drive_heads();
        @(negedge aclk);
        if (reg_wr_req && req_len == 0) begin
            if (ack_q.size() > 0) begin
                cur_ack = ack_q.pop_front();
                cur_err = err_q.pop_front();
            end else begin
                cur_ack = 1;
                cur_err = 1'b0;
            end
        end
        reg_ack   = reg_wr_req && (cur_ack != 0) && (req_len + 1 == cur_ack);
        reg_err   = reg_ack ? cur_err : 1'($urandom_range(1));
        b_wr_full = (full_left > 0) || (rand_full && $urandom_range(3) == 0);
        #1;
        cyc++;
        popped = aresetn && aw_rd_en && w_rd_en;
        if (aresetn) begin
            if (aw_rd_en !== w_rd_en) inv_bad++;
            if (popped && (aw_rd_empty || w_rd_empty || busy)) inv_bad++;
            if (!popped && !busy && !aw_rd_empty && !w_rd_empty) inv_bad++;
            if (b_wr_en && (b_wr_full || !busy || reg_wr_req)) inv_bad++;
        end
        if (popped) begin
            pops++;
            pop_cyc_q.push_back(cyc);
        end
        if (reg_wr_req) begin
            if (req_len == 0) begin
                req_cyc_q.push_back(cyc);
                req_addr_q.push_back(reg_addr);
                req_data_q.push_back(reg_wdata);
                req_strb_q.push_back(reg_wstrb);
            end else if ({reg_addr, reg_wdata, reg_wstrb} !== {req_addr_q[$], req_data_q[$], req_strb_q[$]}) begin
                inv_bad++;
            end
            req_len++;
        end else if (req_len > 0) begin
            req_len_q.push_back(req_len);
            req_len = 0;
        end
        if (b_wr_en) begin
            resp_q.push_back(b_resp);
            push_cyc_q.push_back(cyc);
        end
        if (busy && !reg_wr_req && b_wr_full) stall++;
        if (busy && !reg_wr_req && full_left > 0) full_left--;
        @(posedge aclk);
        #1;
        if (popped) begin
            void'(aw_q.pop_front());
            void'(wd_q.pop_front());
            void'(ws_q.pop_front());
        end
        drive_heads();
    endtask

    task automatic wait_resp(input int n, input int budget, output bit ok);
        int k = 0;
        while (resp_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (resp_q.size() >= n);
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        aw_q.push_back(a); wd_q.push_back(d); ws_q.push_back(s);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        aw_q.delete(); wd_q.delete(); ws_q.delete();
        drive_heads();
        repeat (3) @(posedge aclk);
        #1;
        n_total++;
        if ({busy, reg_wr_req, b_resp, reg_addr, reg_wdata, reg_wstrb, err_cnt, b_wr_en, aw_rd_en} !== '0)
            $display("FAIL reset_outputs got busy=%b req=%b resp=%b addr=%h data=%h strb=%h cnt=%0d ben=%b want all zero",
                     busy, reg_wr_req, b_resp, reg_addr, reg_wdata, reg_wstrb, err_cnt, b_wr_en);
        else n_pass++;
        aresetn = 1'b1;
        exp_err = 0;
        req_len = 0;
        clear_logs();
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        ack_q.push_back(1); err_q.push_back(1'b0);
        push_pair(32'h10, 32'hA5A5_A5A5, 4'hF);
        wait_resp(1, 20, ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL single_done got %0d responses want 1", resp_q.size()); else n_pass++;
        if (ok && req_cyc_q.size() == 1) begin
            n_total++;
            if ({req_addr_q[0], req_data_q[0], req_strb_q[0]} !== {32'h10, 32'hA5A5_A5A5, 4'hF})
                $display("FAIL single_bus got %h/%h/%h want 00000010/a5a5a5a5/f", req_addr_q[0], req_data_q[0], req_strb_q[0]);
            else n_pass++;
            n_total++;
            if ({req_cyc_q[0] - pop_cyc_q[0], push_cyc_q[0] - pop_cyc_q[0], req_len_q[0]} !== {32'd1, 32'd2, 32'd1})
                $display("FAIL single_timing got req@+%0d push@+%0d len=%0d want +1 +2 1",
                         req_cyc_q[0] - pop_cyc_q[0], push_cyc_q[0] - pop_cyc_q[0], req_len_q[0]);
            else n_pass++;
            n_total++;
            if ({resp_q[0], err_cnt, busy} !== {2'b00, 16'(exp_err), 1'b0})
                $display("FAIL single_resp got resp=%b cnt=%0d busy=%b want 00 %0d 0", resp_q[0], err_cnt, busy, exp_err);
            else n_pass++;
        end
    endtask

    task automatic test_lone_aw();
        bit ok;
        clear_logs();
        ack_q.push_back(1); err_q.push_back(1'b0);
        aw_q.push_back(32'h20);
        repeat (5) tick();
        n_total++;
        if ({pops, 31'(busy)} !== {32'd0, 31'd0}) $display("FAIL lone_aw_wait got pops=%0d busy=%b want 0 0", pops, busy);
        else n_pass++;
        wd_q.push_back(32'h1234_5678); ws_q.push_back(4'h3);
        wait_resp(1, 20, ok);
        n_total++;
        if ({ok, pops, inv_bad} !== {1'b1, 32'd1, 32'd0})
            $display("FAIL lone_aw_pair got done=%b pops=%0d inv=%0d want 1 1 0", ok, pops, inv_bad);
        else n_pass++;
        n_total++;
        if ({req_addr_q.size() == 1, resp_q.size() == 1} !== 2'b11 || req_addr_q[0] !== 32'h20 || resp_q[0] !== 2'b00)
            $display("FAIL lone_aw_write got nreq=%0d resp_n=%0d want addr 20 OKAY", req_addr_q.size(), resp_q.size());
        else n_pass++;
    endtask

    task automatic test_decode();
        bit ok;
        clear_logs();
        ack_q.push_back(1); err_q.push_back(1'b0);
        push_pair(32'h0001_0000, 32'h1, 4'h1);
        push_pair(32'hFFFF_FFFF, 32'h2, 4'h2);
        push_pair(32'h0000_FFFF, 32'h3, 4'h0);
        wait_resp(3, 40, ok);
        exp_err += 2;
        n_total++;
        if (ok !== 1'b1 || req_addr_q.size() != 1) $display("FAIL decode_count got resp=%0d req=%0d want 3 1", resp_q.size(), req_addr_q.size());
        else n_pass++;
        if (ok && req_addr_q.size() == 1) begin
            n_total++;
            if ({resp_q[0], resp_q[1], resp_q[2]} !== {2'b11, 2'b11, 2'b00})
                $display("FAIL decode_resp got %b %b %b want 11 11 00", resp_q[0], resp_q[1], resp_q[2]);
            else n_pass++;
            n_total++;
            if ({req_addr_q[0], req_strb_q[0], push_cyc_q[0] - pop_cyc_q[0]} !== {32'h0000_FFFF, 4'h0, 32'd1})
                $display("FAIL decode_edge got addr=%h strb=%h decerr_lat=%0d want 0000ffff 0 1",
                         req_addr_q[0], req_strb_q[0], push_cyc_q[0] - pop_cyc_q[0]);
            else n_pass++;
        end
        n_total++;
        if (err_cnt !== 16'(exp_err)) $display("FAIL decode_errcnt got %0d want %0d", err_cnt, exp_err);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        int acks[4] = '{0, 8, 3, 9};
        logic errs[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int exp_len[4] = '{8, 8, 3, 8};
        logic [1:0] exp_rsp[4] = '{2'b10, 2'b00, 2'b10, 2'b10};
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            ack_q.push_back(acks[i]); err_q.push_back(errs[i]);
            push_pair(32'h100 + 32'(i * 4), $urandom, 4'($urandom_range(15)));
        end
        wait_resp(4, 100, ok);
        exp_err += 3;
        n_total++;
        if (ok !== 1'b1 || req_len_q.size() != 4) $display("FAIL timeout_done got resp=%0d lens=%0d want 4 4", resp_q.size(), req_len_q.size());
        else n_pass++;
        if (ok && req_len_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_total++;
                if ({req_len_q[i], resp_q[i]} !== {exp_len[i], exp_rsp[i]})
                    $display("FAIL timeout_case%0d got len=%0d resp=%b want %0d %b", i, req_len_q[i], resp_q[i], exp_len[i], exp_rsp[i]);
                else n_pass++;
            end
        end
        n_total++;
        if (err_cnt !== 16'(exp_err)) $display("FAIL timeout_errcnt got %0d want %0d", err_cnt, exp_err);
        else n_pass++;
    endtask

    task automatic test_bfull();
        bit ok;
        clear_logs();
        full_left = 10;
        ack_q.push_back(1); err_q.push_back(1'b0);
        ack_q.push_back(1); err_q.push_back(1'b0);
        push_pair(32'h40, 32'hCAFE_0001, 4'hF);
        push_pair(32'h44, 32'hCAFE_0002, 4'hC);
        wait_resp(2, 60, ok);
        n_total++;
        if ({ok, stall, inv_bad} !== {1'b1, 32'd10, 32'd0})
            $display("FAIL bfull_stall got done=%b stall=%0d inv=%0d want 1 10 0", ok, stall, inv_bad);
        else n_pass++;
        if (ok && pop_cyc_q.size() == 2) begin
            n_total++;
            if ({push_cyc_q[0] - pop_cyc_q[0], 31'(pop_cyc_q[1] > push_cyc_q[0])} !== {32'd12, 31'd1})
                $display("FAIL bfull_order got push@+%0d second_pop=%0d first_push=%0d want +12 and later",
                         push_cyc_q[0] - pop_cyc_q[0], pop_cyc_q[1], push_cyc_q[0]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k = 0;
        clear_logs();
        ack_q.push_back(0); err_q.push_back(1'b0);
        push_pair(32'h80, 32'hDEAD_0000, 4'hF);
        while (!reg_wr_req && k < 10) begin tick(); k++; end
        tick(); tick();
        n_total++;
        if (reg_wr_req !== 1'b1) $display("FAIL rstmid_in_req got req=%b want 1", reg_wr_req); else n_pass++;
        aresetn = 1'b0;
        #1;
        n_total++;
        if ({busy, reg_wr_req, b_resp, reg_addr, reg_wdata, reg_wstrb, err_cnt, b_wr_en} !== '0)
            $display("FAIL rstmid_outputs got busy=%b req=%b resp=%b addr=%h data=%h cnt=%0d want all zero",
                     busy, reg_wr_req, b_resp, reg_addr, reg_wdata, err_cnt);
        else n_pass++;
        tick(); tick();
        aresetn = 1'b1;
        exp_err = 0;
        req_len = 0;
        ack_q.delete(); err_q.delete();
        clear_logs();
        ack_q.push_back(1); err_q.push_back(1'b0);
        push_pair(32'h84, 32'hBEEF_0001, 4'h5);
        wait_resp(1, 20, ok);
        repeat (3) tick();
        n_total++;
        if (ok !== 1'b1 || resp_q.size() != 1 || req_addr_q.size() != 1)
            $display("FAIL rstmid_next got resp=%0d req=%0d want 1 1", resp_q.size(), req_addr_q.size());
        else if ({resp_q[0], req_addr_q[0], req_data_q[0], err_cnt} !== {2'b00, 32'h84, 32'hBEEF_0001, 16'd0})
            $display("FAIL rstmid_next got resp=%b addr=%h data=%h cnt=%0d want 00 84 beef0001 0",
                     resp_q[0], req_addr_q[0], req_data_q[0], err_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        localparam int N = 60;
        logic [31:0] ra[N];
        logic [31:0] rd[N];
        logic [3:0]  rs[N];
        logic [1:0]  e_rsp[N];
        logic [99:0] e_req[$];
        int ai = 0;
        int wi = 0;
        int k = 0;
        clear_logs();
        rand_full = 1;
        for (int i = 0; i < N; i++) begin
            int a_at;
            logic er;
            if ($urandom_range(4) == 0) ra[i] = {16'($urandom_range(1, 16'hFFFF)), 16'($urandom)};
            else ra[i] = 32'($urandom_range(0, 16'hFFFF));
            rd[i] = $urandom;
            rs[i] = 4'($urandom_range(15));
            if ({1'b0, ra[i]} >= {1'b0, BASE_P} && {1'b0, ra[i]} < {1'b0, BASE_P} + SIZE_P) begin
                a_at = $urandom_range(0, 10);
                er = 1'($urandom_range(1));
                ack_q.push_back(a_at); err_q.push_back(er);
                if (a_at >= 1 && a_at <= TMO) begin
                    e_rsp[i] = er ? 2'b10 : 2'b00;
                    e_req.push_back({ra[i] - BASE_P, rd[i], rs[i], 32'(a_at)});
                end else begin
                    e_rsp[i] = 2'b10;
                    e_req.push_back({ra[i] - BASE_P, rd[i], rs[i], 32'(TMO)});
                end
            end else begin
                e_rsp[i] = 2'b11;
            end
            if (e_rsp[i] != 2'b00) exp_err++;
        end
        while (resp_q.size() < N && k < 3000) begin
            if (ai < N && $urandom_range(1) == 1) begin aw_q.push_back(ra[ai]); ai++; end
            if (wi < N && $urandom_range(1) == 1) begin wd_q.push_back(rd[wi]); ws_q.push_back(rs[wi]); wi++; end
            tick();
            k++;
        end
        repeat (2) tick();
        rand_full = 0;
        n_total++;
        if ({resp_q.size(), req_len_q.size(), pops, inv_bad} !== {N, e_req.size(), N, 0})
            $display("FAIL random_counts got resp=%0d req=%0d pops=%0d inv=%0d want %0d %0d %0d 0",
                     resp_q.size(), req_len_q.size(), pops, inv_bad, N, e_req.size(), N);
        else n_pass++;
        if (resp_q.size() == N) begin
            for (int i = 0; i < N; i++) begin
                n_total++;
                if (resp_q[i] !== e_rsp[i]) $display("FAIL random_resp%0d got %b want %b", i, resp_q[i], e_rsp[i]);
                else n_pass++;
            end
        end
        if (req_len_q.size() == e_req.size()) begin
            for (int i = 0; i < e_req.size(); i++) begin
                n_total++;
                if ({req_addr_q[i], req_data_q[i], req_strb_q[i], 32'(req_len_q[i])} !== e_req[i])
                    $display("FAIL random_req%0d got %h/%h/%h len=%0d want %h", i, req_addr_q[i], req_data_q[i],
                             req_strb_q[i], req_len_q[i], e_req[i]);
                else n_pass++;
            end
        end
        n_total++;
        if (err_cnt !== 16'(exp_err)) $display("FAIL random_errcnt got %0d want %0d", err_cnt, exp_err);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_lone_aw();
        test_decode();
        test_timeout();
        test_bfull();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
